multicycle_mem_responder: RTL and testbench
===========================================

// Module: multicycle_mem_responder
// PURPOSE
//   Main-memory responder for the cache fill path. Accepts one word request
//   per cycle (read or write) and returns read data after a fixed LATENCY,
//   flagged by data_valid. Fully pipelined: back-to-back reads return as
//   back-to-back valid words, so an 8-word block fill streams in 8 cycles.
//   Sits below the I/D cache fill FSMs, shared through the memory arbiter.
// PARAMETERS
//   LATENCY  4   cycles from read issue edge to data_valid; legal range 1..8
//   MEM_AW   15  word-address bits stored (addr[MEM_AW:1]); higher bits ignored
// PORTS
//   clk         in   1   clock, rising-edge
//   rst_n       in   1   asynchronous active-low reset
//   enable      in   1   request valid this cycle
//   wr          in   1   1 = write, 0 = read (qualified by enable)
//   addr        in   16  byte address; addr[0] ignored (word aligned)
//   data_in     in   16  write data
//   data_out    out  16  read data; 0 whenever data_valid is low
//   data_valid  out  1   data_out holds a returned read word this cycle
// BEHAVIOUR
//   Reset (rst_n low, async): pipeline valid bits cleared, data_valid=0,
//     data_out=0. Storage array is NOT cleared; simulation initial contents 0.
//   Read: enable=1, wr=0 sampled at edge E. Word mem[addr[MEM_AW:1]] is read
//     at E and captured into pipeline stage 1. Word shifts one stage per edge;
//     data_valid=1 with that word on data_out for exactly one cycle, starting
//     at edge E+LATENCY-1 (i.e. visible in the LATENCY-th cycle after issue).
//     LATENCY=1: valid in the cycle directly after the issue edge.
//   Snapshot rule: read data is taken at issue; writes to the same word in
//     cycles after the issue do not change in-flight data.
//   Write: enable=1, wr=1 at edge E stores data_in to mem[addr[MEM_AW:1]] at
//     E. No data_valid generated; that pipeline slot carries a bubble.
//   enable=0: bubble inserted; no storage change.
//   Pipeline: LATENCY-deep shift of {valid, data}; a new request is accepted
//     every cycle, no backpressure, no stall output, no request ordering
//     other than FIFO (returns in issue order).
//   Address: addr[0] ignored; addr[15:MEM_AW+1] ignored (aliases).
//   Read then write to same word in consecutive cycles: read returns old value.
//   Reset mid-operation: all in-flight reads discarded; no data_valid pulses
//     after rst_n rises until new reads are issued; stored words retained,
//     including any write sampled at an edge before reset asserted.
//   data_out and data_valid are registered outputs (no comb path from inputs).
// TESTING
//   1 Reset: hold rst_n=0, toggle enable/wr -> data_valid=0, data_out=0 all
//     cycles; release -> still 0 with enable=0.
//   2 Single read latency: preload mem[0x0918]=0xBEEF; read addr 0x1230 at
//     edge E -> data_valid=1, data_out=0xBEEF only in cycle after E+3; 0 else.
//   3 Block burst: preload words 0x1230..0x123E with 0xA000..0xA007; issue 8
//     reads, addr +2 per cycle -> 8 consecutive valid cycles, data in order,
//     data_valid falls right after the eighth word.
//   4 Write/read and snapshot: write 0x1234 to 0x0040; read 0x0040 next cycle
//     -> returns 0x1234; read 0x0040 then write 0x5555 next cycle -> old 0x1234.
//   5 Mixed: read,write,bubble,read stream -> valid pattern 1,0,0,1 delayed
//     by LATENCY; addr 0x0041 reads same word as 0x0040.
//   6 Reset mid-burst: assert rst_n=0 after 3 of 8 reads issued, mid-cycle ->
//     data_valid drops immediately, no stale words after release; earlier
//     writes still readable.

Source files
------------

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency, fully pipelined word memory for the cache fill path.
// Read data is captured when the read issues, then travels down a LATENCY-deep shift of {valid, data}.
module multicycle_mem_responder #(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid
);

    logic [15:0]               mem [2**MEM_AW];
    logic [MEM_AW-1:0]         word_idx;
    logic                      rd_req;
    logic [LATENCY-1:0]        vld_pipe;
    logic [LATENCY-1:0][15:0]  data_pipe;
    logic                      addr_unused;

    assign word_idx    = addr[MEM_AW:1];
    assign rd_req      = enable && !wr;
    assign addr_unused = ^addr;

    // Storage has no reset so words written before a reset survive it.
    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem[word_idx] <= data_in;
        end
    end

    // Bubbles carry zero data, so data_out is already 0 whenever data_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_req;
            data_pipe[0] <= rd_req ? mem[word_idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign data_out   = data_pipe[LATENCY-1];
    assign data_valid = vld_pipe[LATENCY-1];

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Randomized and directed bench for multicycle_mem_responder, checked against a
// cycle-indexed schedule of expected returns plus a word-addressed memory model.
module tb_multicycle_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;

    // Model: memory keyed by word address, and expected return keyed by edge number.
    logic [15:0] model_mem [int];
    logic [15:0] exp_at [int];

    multicycle_mem_responder #(.LATENCY(LAT), .MEM_AW(15)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
        .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        int k;
        k = int'(a[15:1]);
        return model_mem.exists(k) ? model_mem[k] : 16'h0000;
    endfunction

    // Called at a negedge: drives one request, lets the edge pass, and reports
    // what the outputs should show in the cycle following that edge.
    task automatic drive_cycle(input logic en, input logic w, input logic [15:0] a,
                               input logic [15:0] d, output logic ev, output logic [15:0] ed);
        enable = en; wr = w; addr = a; data_in = d;
        @(posedge clk);
        edge_cnt++;
        if (en) begin
            if (w) model_mem[int'(a[15:1])] = d;
            else   exp_at[edge_cnt + LAT - 1] = model_rd(a);
        end
        @(negedge clk);
        enable = 1'b0; wr = 1'b0;
        if (exp_at.exists(edge_cnt)) begin
            ev = 1'b1; ed = exp_at[edge_cnt];
        end else begin
            ev = 1'b0; ed = 16'h0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable = i[0]; wr = i[1]; addr = 16'h7F00; data_in = 16'h1111;
            @(negedge clk);
            vectors++;
            if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: got v=%b d=%h, want v=0 d=0000", i, data_valid, data_out);
            end
        end
        enable = 1'b0; wr = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_release cyc%0d: got v=%b d=%h, want v=0 d=0000", i, data_valid, data_out);
            end
        end
    endtask

    task automatic test_single_read();
        logic ev; logic [15:0] ed;
        int seen_at;
        seen_at = -1;
        drive_cycle(1'b1, 1'b1, 16'h1230, 16'hBEEF, ev, ed);
        drive_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, ev, ed);
        for (int i = 0; i < LAT + 3; i++) begin
            drive_cycle(i == 0, 1'b0, 16'h1230, 16'h0000, ev, ed);
            vectors++;
            if (data_valid && seen_at < 0) seen_at = i;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL single_read cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
        vectors++;
        if (seen_at !== LAT - 1) begin
            miscompares++;
            $display("FAIL single_read_latency: got valid after cycle %0d, want %0d", seen_at, LAT - 1);
        end
    endtask

    task automatic test_block_burst();
        logic ev; logic [15:0] ed;
        int run;
        run = 0;
        for (int i = 0; i < 8; i++)
            drive_cycle(1'b1, 1'b1, 16'h1230 + 16'(2 * i), 16'hA000 + 16'(i), ev, ed);
        for (int i = 0; i < 8 + LAT + 2; i++) begin
            drive_cycle(i < 8, 1'b0, 16'h1230 + 16'(2 * i), 16'h0000, ev, ed);
            vectors++;
            if (data_valid) run++;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL burst cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
        vectors++;
        if (run !== 8) begin
            miscompares++;
            $display("FAIL burst_count: got %0d valid words, want 8", run);
        end
    endtask

    task automatic test_write_read_snapshot();
        logic ev; logic [15:0] ed;
        logic [3:0] en_seq  = 4'b1111;
        logic [3:0] wr_seq  = 4'b1001;
        logic [15:0] wd [4] = '{16'h1234, 16'h0000, 16'h0000, 16'h5555};
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 4) drive_cycle(en_seq[i], wr_seq[i], 16'h0040, wd[i], ev, ed);
            else       drive_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, ev, ed);
            vectors++;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL snapshot cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
        vectors++;
        if (model_rd(16'h0040) !== 16'h5555) begin
            miscompares++;
            $display("FAIL snapshot_model: got %h, want 5555", model_rd(16'h0040));
        end
    endtask

    task automatic test_mixed();
        logic ev; logic [15:0] ed;
        logic [15:0] a_seq [4] = '{16'h0041, 16'h0044, 16'h0000, 16'h0040};
        logic [3:0] en_seq = 4'b1011;
        logic [3:0] wr_seq = 4'b0010;
        logic [3:0] got_pat;
        got_pat = 4'b0000;
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 4) drive_cycle(en_seq[i], wr_seq[i], a_seq[i], 16'h7777, ev, ed);
            else       drive_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, ev, ed);
            vectors++;
            if (i >= LAT - 1 && i < LAT + 3) got_pat[i - (LAT - 1)] = data_valid;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL mixed cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
        vectors++;
        if (got_pat !== 4'b1001) begin
            miscompares++;
            $display("FAIL mixed_pattern: got %b, want 1001 (bit0 first)", got_pat);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ev; logic [15:0] ed;
        drive_cycle(1'b1, 1'b1, 16'h0500, 16'hC0DE, ev, ed);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0000, ev, ed);
        #2;
        rst_n = 1'b0;
        #1;
        exp_at.delete();
        vectors++;
        if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_drop: got v=%b d=%h, want v=0 d=0000", data_valid, data_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            drive_cycle(i == 2, 1'b0, 16'h0500, 16'h0000, ev, ed);
            vectors++;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL reset_mid_after cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
    endtask

    task automatic test_random();
        logic ev; logic [15:0] ed;
        logic [15:0] a;
        for (int k = 0; k < 16; k++)
            drive_cycle(1'b1, 1'b1, 16'h0100 + 16'(2 * k), 16'($urandom), ev, ed);
        for (int i = 0; i < 300; i++) begin
            a = 16'h0100 + 16'(2 * $urandom_range(0, 15)) + 16'($urandom_range(0, 1));
            if (i < 290) drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), a, 16'($urandom), ev, ed);
            else         drive_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, ev, ed);
            vectors++;
            if (data_valid !== ev || data_out !== ed) begin
                miscompares++;
                $display("FAIL random cyc%0d: got v=%b d=%h, want v=%b d=%h", i, data_valid, data_out, ev, ed);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_block_burst();
        test_write_read_snapshot();
        test_mixed();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
